// File: rtl/mem_pkg.sv
// Shared definitions for the MEM-stage load/store engine.
// Contents:
//   SZ_*          access size encodings carried on req_size
//   EXC_ADEL/ADES address-error exception codes for misaligned load/store
//   memState_t    bus handshake FSM states
//   sizeMask      byte-enable mask of an access before lane shifting
package mem_pkg;

    localparam logic [1:0] SZ_BYTE  = 2'b00;
    localparam logic [1:0] SZ_HALF  = 2'b01;
    localparam logic [1:0] SZ_WORD  = 2'b10;
    localparam logic [1:0] SZ_DWORD = 2'b11;

    localparam logic [3:0] EXC_ADEL = 4'h4;
    localparam logic [3:0] EXC_ADES = 4'h5;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ADDR,
        ST_DATA,
        ST_DRAIN
    } memState_t;

    function automatic logic [7:0] sizeMask(input logic [1:0] size);
        case (size)
            SZ_BYTE: sizeMask = 8'h01;
            SZ_HALF: sizeMask = 8'h03;
            SZ_WORD: sizeMask = 8'h0F;
            default: sizeMask = 8'hFF;
        endcase
    endfunction

endpackage

// File: rtl/mem_align.sv
// Combinational lane logic for the MEM stage.
// Store side (live request): byte enables, store data replicated across lanes,
// misalignment flag. Load side (latched request): shift returned bus data down
// to lane 0 and sign/zero-extend it from the access size.
// Ports:
//   stSize, stOffset, stWdata   store-side request size, byte offset, right-aligned data
//   be, wdataLanes, misaligned  steered byte enables / data, alignment fault
//   ldSize, ldUnsigned, ldOffset, ldRdata   load-side size, extension mode, offset, bus data
//   ldData                      extended load result
module mem_align
    import mem_pkg::*;
#(
    parameter int DATA_W = 32,
    localparam int BEW   = DATA_W / 8,
    localparam int OFFW  = $clog2(DATA_W / 8)
) (
    input  logic [1:0]        stSize,
    input  logic [OFFW-1:0]   stOffset,
    input  logic [DATA_W-1:0] stWdata,
    output logic [BEW-1:0]    be,
    output logic [DATA_W-1:0] wdataLanes,
    output logic              misaligned,
    input  logic [1:0]        ldSize,
    input  logic              ldUnsigned,
    input  logic [OFFW-1:0]   ldOffset,
    input  logic [DATA_W-1:0] ldRdata,
    output logic [DATA_W-1:0] ldData
);

    function automatic logic [DATA_W-1:0] extendLoad(input logic [DATA_W-1:0] v,
                                                     input logic [1:0] size,
                                                     input logic zeroExt);
        logic [DATA_W-1:0] r;
        case (size)
            SZ_BYTE: if (zeroExt) r = DATA_W'(v[7:0]);  else r = DATA_W'($signed(v[7:0]));
            SZ_HALF: if (zeroExt) r = DATA_W'(v[15:0]); else r = DATA_W'($signed(v[15:0]));
            SZ_WORD: if (zeroExt) r = DATA_W'(v[31:0]); else r = DATA_W'($signed(v[31:0]));
            default: r = v;
        endcase
        return r;
    endfunction

    logic [DATA_W-1:0] shifted;

    always_comb begin
        misaligned = 1'b0;
        case (stSize)
            SZ_BYTE: misaligned = 1'b0;
            SZ_HALF: misaligned = (stOffset & OFFW'(1)) != '0;
            SZ_WORD: misaligned = (stOffset & OFFW'(3)) != '0;
            // A doubleword cannot be carried at all on a 32-bit bus.
            default: misaligned = (DATA_W != 64) || ((stOffset & OFFW'(7)) != '0);
        endcase
    end

    always_comb begin
        be = BEW'(sizeMask(stSize)) << stOffset;
        case (stSize)
            SZ_BYTE: wdataLanes = {BEW{stWdata[7:0]}};
            SZ_HALF: wdataLanes = {(BEW/2){stWdata[15:0]}};
            SZ_WORD: wdataLanes = {(BEW/4){stWdata[31:0]}};
            default: wdataLanes = stWdata;
        endcase
    end

    always_comb begin
        shifted = ldRdata >> {ldOffset, 3'b000};
        ldData  = extendLoad(shifted, ldSize, ldUnsigned);
    end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store engine. Accepts one instruction at a time from EX/MEM,
// resolves illegal or non-memory instructions in one cycle, and runs legal
// accesses over an SRAM-like bus (req/addr_ok/data_ok) while stalling upstream.
// Ports:
//   clk, rst                    clock, asynchronous active-low reset
//   req_valid/mem/we/size/unsigned/addr/wdata/exc   instruction from EX/MEM
//   flush                       cancel the current instruction
//   stall_out                   hold upstream stages
//   bus_req/wr/be/addr/wdata    registered bus request (address aligned to DATA_W/8)
//   bus_addr_ok, bus_data_ok    bus accept / completion strobes
//   bus_rdata                   bus read data
//   resp_valid/rdata/exc/badvaddr   one-cycle result to MEM/WB
module mem_access_unit
    import mem_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int EXC_W  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    input  logic              req_mem,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [EXC_W-1:0]  req_exc,
    input  logic              flush,
    output logic              stall_out,
    output logic              bus_req,
    output logic              bus_wr,
    output logic [DATA_W/8-1:0] bus_be,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wdata,
    input  logic              bus_addr_ok,
    input  logic              bus_data_ok,
    input  logic [DATA_W-1:0] bus_rdata,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic [EXC_W-1:0]  resp_exc,
    output logic [ADDR_W-1:0] resp_badvaddr
);

    localparam int BEW  = DATA_W / 8;
    localparam int OFFW = $clog2(BEW);

    memState_t         state, stateNext;
    logic [1:0]        ldSize;
    logic              ldUnsigned;
    logic [OFFW-1:0]   ldOffset;
    logic [BEW-1:0]    alignBe;
    logic [DATA_W-1:0] alignWdata;
    logic [DATA_W-1:0] alignLoad;
    logic              misaligned;
    logic              addrFault;
    logic [EXC_W-1:0]  passExc;
    logic              accept, passResp, loadDone, stallOut;

    mem_align #(.DATA_W(DATA_W)) uAlign (
        .stSize     (req_size),
        .stOffset   (req_addr[OFFW-1:0]),
        .stWdata    (req_wdata),
        .be         (alignBe),
        .wdataLanes (alignWdata),
        .misaligned (misaligned),
        .ldSize     (ldSize),
        .ldUnsigned (ldUnsigned),
        .ldOffset   (ldOffset),
        .ldRdata    (bus_rdata),
        .ldData     (alignLoad)
    );

    // Upstream exceptions take priority over the address-error check.
    always_comb begin
        addrFault = req_mem && (req_exc == '0) && misaligned;
        passExc   = '0;
        if (req_exc != '0)
            passExc = req_exc;
        else if (addrFault)
            passExc = req_we ? EXC_W'(EXC_ADES) : EXC_W'(EXC_ADEL);
    end

    always_comb begin
        stateNext = state;
        accept    = 1'b0;
        passResp  = 1'b0;
        loadDone  = 1'b0;
        stallOut  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (req_valid && !flush) begin
                    if (!req_mem || (req_exc != '0) || misaligned) begin
                        passResp = 1'b1;
                    end else begin
                        accept    = 1'b1;
                        stallOut  = 1'b1;
                        stateNext = ST_ADDR;
                    end
                end
            end
            ST_ADDR: begin
                stallOut = !flush;
                // An accepted request must still be drained even if flushed now.
                if (bus_addr_ok)
                    stateNext = flush ? ST_DRAIN : ST_DATA;
                else if (flush)
                    stateNext = ST_IDLE;
            end
            ST_DATA: begin
                if (bus_data_ok) begin
                    stateNext = ST_IDLE;
                    loadDone  = !flush;
                end else if (flush) begin
                    stateNext = ST_DRAIN;
                end else begin
                    stallOut = 1'b1;
                end
            end
            ST_DRAIN: begin
                stallOut = req_valid;
                if (bus_data_ok)
                    stateNext = ST_IDLE;
            end
            default: stateNext = ST_IDLE;
        endcase
    end

    assign bus_req   = (state == ST_ADDR);
    assign stall_out = stallOut & rst;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= ST_IDLE;
            bus_wr        <= 1'b0;
            bus_be        <= '0;
            bus_addr      <= '0;
            bus_wdata     <= '0;
            resp_valid    <= 1'b0;
            resp_rdata    <= '0;
            resp_exc      <= '0;
            resp_badvaddr <= '0;
        end else begin
            state      <= stateNext;
            resp_valid <= passResp | loadDone;
            if (accept) begin
                bus_wr    <= req_we;
                bus_be    <= alignBe;
                bus_addr  <= {req_addr[ADDR_W-1:OFFW], {OFFW{1'b0}}};
                bus_wdata <= alignWdata;
            end
            if (passResp) begin
                resp_rdata    <= '0;
                resp_exc      <= passExc;
                resp_badvaddr <= addrFault ? req_addr : '0;
            end else if (loadDone) begin
                resp_rdata    <= bus_wr ? '0 : alignLoad;
                resp_exc      <= '0;
                resp_badvaddr <= '0;
            end
        end
    end

    // Load shaping info is only consumed after an accept, so it needs no reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            ldSize     <= req_size;
            ldUnsigned <= req_unsigned;
            ldOffset   <= req_addr[OFFW-1:0];
        end
    end

endmodule
